// File: rtl/axi_to_wb_bresp_gen_if.sv
// ---------------------------------------------------------------------------
// axi_to_wb_bresp_gen_if
// Bundles the signals that go to and from the write-response generator:
//   AW side : id_push, id_in, id_full
//   WB side : wr_start, start_ready, wb_ack, wb_err, wb_rty
//   AXI B   : axi_bid, axi_bresp, axi_bvalid, axi_bready
//   status  : resp_busy, timeout_err
// slave  = the response generator, master = whoever drives it.
// ---------------------------------------------------------------------------
interface axi_to_wb_bresp_gen_if #(
  parameter int ID_WIDTH = 4
);
  logic                id_push;
  logic [ID_WIDTH-1:0] id_in;
  logic                id_full;
  logic                wr_start;
  logic                start_ready;
  logic                wb_ack;
  logic                wb_err;
  logic                wb_rty;
  logic [ID_WIDTH-1:0] axi_bid;
  logic [1:0]          axi_bresp;
  logic                axi_bvalid;
  logic                axi_bready;
  logic                resp_busy;
  logic                timeout_err;

  modport slave (
    input  id_push, id_in, wr_start, wb_ack, wb_err, wb_rty, axi_bready,
    output id_full, start_ready, axi_bid, axi_bresp, axi_bvalid,
           resp_busy, timeout_err
  );

  modport master (
    output id_push, id_in, wr_start, wb_ack, wb_err, wb_rty, axi_bready,
    input  id_full, start_ready, axi_bid, axi_bresp, axi_bvalid,
           resp_busy, timeout_err
  );
endinterface

// File: rtl/axi_to_wb_bresp_gen.sv
// ---------------------------------------------------------------------------
// axi_to_wb_bresp_gen
// AXI write-response (B channel) generator for the AXI-to-Wishbone bridge.
// AWIDs are queued at AW handshakes; each Wishbone write is tracked from
// acceptance to termination (ACK/ERR/RTY or watchdog), the result is mapped
// to a BRESP and presented with the queue-head ID until the master takes it.
//
// Ports:
//   ACLK     clock, rising edge
//   ARESETN  asynchronous active-low reset
//   bus      axi_to_wb_bresp_gen_if.slave (ID queue, WB tracking, AXI B,
//            status)
// ---------------------------------------------------------------------------
module axi_to_wb_bresp_gen #(
  parameter int ID_WIDTH         = 4,
  parameter int ID_FIFO_DEPTH    = 4,    // power of 2, >= 2
  parameter int TIMEOUT_CYCLES   = 256,  // 0 disables the watchdog
  parameter bit ENABLE_ERROR_MAP = 1'b1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  axi_to_wb_bresp_gen_if.slave  bus
);

  localparam int PW = $clog2(ID_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TLAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(ID_FIFO_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] RESP_ERRMAP = ENABLE_ERROR_MAP ? RESP_SLVERR : RESP_OKAY;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_WB   = 2'd1,
    S_SEND_RESP = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  // ID FIFO
  logic [ID_WIDTH-1:0] r_mem [ID_FIFO_DEPTH];
  logic [PW-1:0]       r_wptr, r_rptr;
  logic [CW-1:0]       r_count, w_count_nxt;
  logic                r_full;
  logic                w_empty, w_full, w_push, w_pop;

  // response path
  logic [TW-1:0]       r_timer, w_timer_nxt;
  logic                r_bvalid, w_bvalid_nxt;
  logic [1:0]          r_bresp, w_bresp_nxt;
  logic [ID_WIDTH-1:0] r_bid, w_bid_nxt;
  logic                r_tout, w_tout_nxt;
  logic                w_start_ready;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = (r_state == S_SEND_RESP) && r_bvalid && bus.axi_bready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push  = bus.id_push && (!w_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
    end
  end

  // Storage needs no reset: nothing is read until count says it is valid.
  always_ff @(posedge ACLK) begin
    if (w_push) r_mem[r_wptr] <= bus.id_in;
  end

  // Start is gated by the registered count only, so an ID arriving in the
  // same cycle cannot satisfy a pending wr_start.
  assign w_start_ready = (r_state == S_IDLE) && !w_empty;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_bvalid_nxt = r_bvalid;
    w_bresp_nxt  = r_bresp;
    w_bid_nxt    = r_bid;
    w_tout_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.wr_start && w_start_ready) begin
          w_state_nxt = S_WAIT_WB;
          w_timer_nxt = '0;
        end
      end
      S_WAIT_WB: begin
        w_timer_nxt = r_timer + 1'b1;
        // A real termination outranks the watchdog in the expiry cycle.
        if (bus.wb_err || bus.wb_rty) begin
          w_state_nxt  = S_SEND_RESP;
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = RESP_ERRMAP;
          w_bid_nxt    = r_mem[r_rptr];
        end else if (bus.wb_ack) begin
          w_state_nxt  = S_SEND_RESP;
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = RESP_OKAY;
          w_bid_nxt    = r_mem[r_rptr];
        end else if (TO_EN && (r_timer == TLAST)) begin
          w_state_nxt  = S_SEND_RESP;
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = RESP_DECERR;
          w_bid_nxt    = r_mem[r_rptr];
          w_tout_nxt   = 1'b1;
        end
      end
      S_SEND_RESP: begin
        if (w_pop) begin
          w_state_nxt  = S_IDLE;
          w_bvalid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_bid    <= '0;
      r_tout   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_bvalid <= w_bvalid_nxt;
      r_bresp  <= w_bresp_nxt;
      r_bid    <= w_bid_nxt;
      r_tout   <= w_tout_nxt;
    end
  end

  assign bus.id_full     = r_full;
  assign bus.start_ready = w_start_ready;
  assign bus.resp_busy   = (r_state != S_IDLE);
  assign bus.axi_bvalid  = r_bvalid;
  assign bus.axi_bresp   = r_bresp;
  assign bus.axi_bid     = r_bid;
  assign bus.timeout_err = r_tout;

endmodule

// File: tb/tb_axi_to_wb_bresp_gen.sv
module tb_axi_to_wb_bresp_gen;
  localparam int IDW   = 4;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  axi_to_wb_bresp_gen_if #(.ID_WIDTH(IDW)) ifa ();
  axi_to_wb_bresp_gen_if #(.ID_WIDTH(IDW)) ifb ();

  // second instance sees identical stimulus, differs only in error mapping
  assign ifb.id_push    = ifa.id_push;
  assign ifb.id_in      = ifa.id_in;
  assign ifb.wr_start   = ifa.wr_start;
  assign ifb.wb_ack     = ifa.wb_ack;
  assign ifb.wb_err     = ifa.wb_err;
  assign ifb.wb_rty     = ifa.wb_rty;
  assign ifb.axi_bready = ifa.axi_bready;

  axi_to_wb_bresp_gen #(.ID_WIDTH(IDW), .ID_FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO), .ENABLE_ERROR_MAP(1'b1)) u_dut_a (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(ifa.slave));

  axi_to_wb_bresp_gen #(.ID_WIDTH(IDW), .ID_FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO), .ENABLE_ERROR_MAP(1'b0)) u_dut_b (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(ifb.slave));

  int errors = 0;
  int checks = 0;

  // ---------------- reference model (transaction level) ----------------
  // phase: 0 idle, 1 waiting for WB, 2 response offered
  int q[$];
  int ph, waited, m_bid, m_code_a, m_code_b;
  bit m_tout;

  function automatic void model_reset();
    q.delete();
    ph = 0; waited = 0; m_bid = 0; m_code_a = 0; m_code_b = 0; m_tout = 1'b0;
  endfunction

  function automatic void model_update();
    bit pop, full;
    pop  = (ph == 2) && ifa.axi_bready;
    full = (q.size() == DEPTH);
    m_tout = 1'b0;
    case (ph)
      0: if (ifa.wr_start && q.size() > 0) begin ph = 1; waited = 0; end
      1: begin
        if (ifa.wb_err || ifa.wb_rty) begin
          m_code_a = 2; m_code_b = 0; m_bid = q[0]; ph = 2;
        end else if (ifa.wb_ack) begin
          m_code_a = 0; m_code_b = 0; m_bid = q[0]; ph = 2;
        end else if (waited == TO - 1) begin
          m_code_a = 3; m_code_b = 3; m_bid = q[0]; ph = 2; m_tout = 1'b1;
        end else begin
          waited++;
        end
      end
      default: if (ifa.axi_bready) ph = 0;
    endcase
    if (pop) void'(q.pop_front());
    if (ifa.id_push && (!full || pop)) q.push_back(int'(ifa.id_in));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("bvalid_a", 32'(ifa.axi_bvalid), 32'(ph == 2));
    chk("bvalid_b", 32'(ifb.axi_bvalid), 32'(ph == 2));
    if (ph == 2) begin
      chk("bid_a",   32'(ifa.axi_bid),   32'(m_bid));
      chk("bid_b",   32'(ifb.axi_bid),   32'(m_bid));
      chk("bresp_a", 32'(ifa.axi_bresp), 32'(m_code_a));
      chk("bresp_b", 32'(ifb.axi_bresp), 32'(m_code_b));
    end
    chk("start_ready_a", 32'(ifa.start_ready), 32'(ph == 0 && q.size() > 0));
    chk("start_ready_b", 32'(ifb.start_ready), 32'(ph == 0 && q.size() > 0));
    chk("resp_busy_a",   32'(ifa.resp_busy),   32'(ph != 0));
    chk("resp_busy_b",   32'(ifb.resp_busy),   32'(ph != 0));
    chk("timeout_err_a", 32'(ifa.timeout_err), 32'(m_tout));
    chk("timeout_err_b", 32'(ifb.timeout_err), 32'(m_tout));
    chk("id_full_a",     32'(ifa.id_full),     32'(q.size() == DEPTH));
    chk("id_full_b",     32'(ifb.id_full),     32'(q.size() == DEPTH));
  endtask

  task automatic drv(input bit p, input int id, input bit s, input bit a,
                     input bit e, input bit r, input bit b);
    ifa.id_push = p; ifa.id_in = id[IDW-1:0]; ifa.wr_start = s;
    ifa.wb_ack = a; ifa.wb_err = e; ifa.wb_rty = r; ifa.axi_bready = b;
  endtask

  task automatic step();
    @(posedge ACLK);
    model_update();
    #1;
    check_all();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       push;
    logic [3:0] id;
    logic       start, ack, err, rty, bready;
    logic       e_bv;
    logic [3:0] e_bid;
    logic [1:0] e_ra, e_rb;
    logic       e_sr, e_busy, e_full;
  } vec_t;

  function automatic vec_t mk(input int p, input int id, input int s, input int a,
                              input int e, input int r, input int b, input int bv,
                              input int bid, input int ra, input int rb,
                              input int sr, input int busy, input int full);
    vec_t v;
    v.push = p[0]; v.id = id[3:0]; v.start = s[0]; v.ack = a[0]; v.err = e[0];
    v.rty = r[0]; v.bready = b[0]; v.e_bv = bv[0]; v.e_bid = bid[3:0];
    v.e_ra = ra[1:0]; v.e_rb = rb[1:0]; v.e_sr = sr[0]; v.e_busy = busy[0];
    v.e_full = full[0];
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    int pulses;
    logic [3:0] hold_bid;

    //            p id s a e r b | bv bid ra rb sr busy full
    tbl[0]  = mk(1, 3, 0,0,0,0,0,  0, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 1,0,0,0,0,  0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0,0,0,0,0,  0, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0,1,0,0,0,  1, 3, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0,0,0,0,1,  0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0,0,0,0,0,  0, 0, 0, 0, 1, 0, 0);
    tbl[6]  = mk(1, 2, 1,0,0,0,0,  0, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0,0,1,0,0,  1, 1, 2, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 0,0,0,0,1,  0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1,0,0,0,0,  0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0,1,0,1,0,  1, 2, 2, 0, 0, 1, 0);
    tbl[11] = mk(0, 0, 0,0,0,0,1,  0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 5, 1,0,0,0,0,  0, 0, 0, 0, 1, 0, 0);  // start on empty FIFO refused
    tbl[13] = mk(0, 0, 1,0,0,0,0,  0, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0,1,0,0,0,  1, 5, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 0,0,0,0,1,  0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0,0,1,0,0,  0, 0, 0, 0, 0, 0, 0);  // err while idle ignored

    // reset state
    drv(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    check_all();
    chk("rst_bid_a",   32'(ifa.axi_bid),   32'd0);
    chk("rst_bresp_a", 32'(ifa.axi_bresp), 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // table
    for (int i = 0; i < 17; i++) begin
      drv(tbl[i].push, int'(tbl[i].id), tbl[i].start, tbl[i].ack, tbl[i].err,
          tbl[i].rty, tbl[i].bready);
      step();
      chk($sformatf("tbl%0d_bvalid", i), 32'(ifa.axi_bvalid), 32'(tbl[i].e_bv));
      chk($sformatf("tbl%0d_sready", i), 32'(ifa.start_ready), 32'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_busy", i),   32'(ifa.resp_busy),  32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_full", i),   32'(ifa.id_full),    32'(tbl[i].e_full));
      if (tbl[i].e_bv) begin
        chk($sformatf("tbl%0d_bid", i),     32'(ifa.axi_bid),   32'(tbl[i].e_bid));
        chk($sformatf("tbl%0d_bresp_a", i), 32'(ifa.axi_bresp), 32'(tbl[i].e_ra));
        chk($sformatf("tbl%0d_bresp_b", i), 32'(ifb.axi_bresp), 32'(tbl[i].e_rb));
      end
    end

    // backpressure: response held stable while bready is low
    drv(1, 7, 0, 0, 0, 0, 0); step();
    drv(0, 0, 1, 0, 0, 0, 0); step();
    drv(0, 0, 0, 1, 0, 0, 0); step();
    hold_bid = ifa.axi_bid;
    chk("bp_first_bid", 32'(hold_bid), 32'd7);
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_bvalid", 32'(ifa.axi_bvalid),  32'd1);
      chk("bp_bid",    32'(ifa.axi_bid),     32'(hold_bid));
      chk("bp_bresp",  32'(ifa.axi_bresp),   32'd0);
      chk("bp_sready", 32'(ifa.start_ready), 32'd0);
    end
    drv(0, 0, 0, 0, 0, 0, 1); step();
    chk("bp_done_bvalid", 32'(ifa.axi_bvalid), 32'd0);
    drv(0, 0, 0, 0, 0, 0, 1); step();
    chk("bp_single_pop", 32'(ifa.start_ready), 32'd0);

    // watchdog: plain expiry, then ack in the expiry cycle
    for (int w = 0; w < 2; w++) begin
      pulses = 0;
      drv(1, 9, 0, 0, 0, 0, 0); step();
      drv(0, 0, 1, 0, 0, 0, 0); step();            // entry edge t0
      for (int k = 1; k <= TO; k++) begin
        drv(0, 0, 0, (w == 1 && k == TO), 0, 0, 0);
        step();
        if (ifa.timeout_err === 1'b1) pulses++;
        if (k < TO) begin
          chk("to_early_bvalid", 32'(ifa.axi_bvalid), 32'd0);
        end else begin
          chk("to_bvalid",  32'(ifa.axi_bvalid), 32'd1);
          chk("to_bresp_a", 32'(ifa.axi_bresp),  (w == 1) ? 32'd0 : 32'd3);
          chk("to_bresp_b", 32'(ifb.axi_bresp),  (w == 1) ? 32'd0 : 32'd3);
        end
      end
      drv(0, 0, 0, 0, 0, 0, 1); step();
      if (ifa.timeout_err === 1'b1) pulses++;
      chk("to_pulses", 32'(pulses), (w == 1) ? 32'd0 : 32'd1);
    end

    // FIFO limits with pointer wrap
    drv(1, 4'hA, 0, 0, 0, 0, 0); step();
    drv(1, 4'hB, 0, 0, 0, 0, 0); step();
    drv(1, 4'hC, 0, 0, 0, 0, 0); step();
    drv(1, 4'hD, 0, 0, 0, 0, 0); step();
    chk("ff_full", 32'(ifa.id_full), 32'd1);
    drv(1, 4'hE, 0, 0, 0, 0, 0); step();        // dropped
    chk("ff_still_full", 32'(ifa.id_full), 32'd1);
    drv(0, 0, 1, 0, 0, 0, 0); step();
    drv(0, 0, 0, 1, 0, 0, 0); step();
    got.push_back(int'(ifa.axi_bid));
    drv(1, 4'hE, 0, 0, 0, 0, 1); step();        // push alongside pop
    chk("ff_push_on_pop_full", 32'(ifa.id_full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 1, 0, 0, 0, 0); step();
      drv(0, 0, 0, 1, 0, 0, 0); step();
      got.push_back(int'(ifa.axi_bid));
      drv(0, 0, 0, 0, 0, 0, 1); step();
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("ff_order%0d", k), 32'(got[k]), 32'(10 + k));
    chk("ff_empty_after", 32'(ifa.start_ready), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int t;
      t = int'($urandom_range(0, 99));
      drv(($urandom_range(0, 99) < 35), int'($urandom_range(0, 15)),
          ($urandom_range(0, 1) == 1),
          (t < 8) || (t >= 15 && t < 17),
          (t >= 8 && t < 12) || (t == 15),
          (t >= 12 && t < 15) || (t == 16),
          ($urandom_range(0, 99) < 60));
      step();
    end

    // drain, then reset while a response is stalled
    drv(0, 0, 0, 0, 0, 0, 1);
    repeat (24) step();
    drv(1, 6, 0, 0, 0, 0, 0); step();
    drv(0, 0, 1, 0, 0, 0, 0); step();
    drv(0, 0, 0, 1, 0, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0); step();
    chk("rmid_pre_bvalid", 32'(ifa.axi_bvalid), 32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    model_reset();
    chk("rmid_bvalid_a", 32'(ifa.axi_bvalid),  32'd0);
    chk("rmid_bvalid_b", 32'(ifb.axi_bvalid),  32'd0);
    chk("rmid_bid",      32'(ifa.axi_bid),     32'd0);
    chk("rmid_bresp",    32'(ifa.axi_bresp),   32'd0);
    chk("rmid_busy",     32'(ifa.resp_busy),   32'd0);
    chk("rmid_sready",   32'(ifa.start_ready), 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    drv(0, 0, 1, 0, 0, 0, 0); step();
    chk("rpost_sready", 32'(ifa.start_ready), 32'd0);
    chk("rpost_busy",   32'(ifa.resp_busy),   32'd0);
    drv(1, 4, 0, 0, 0, 0, 0); step();
    chk("rpost_push_sready", 32'(ifa.start_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
